// File: rtl/ptw_mem_responder_pkg.sv
// Shared types for the PTW memory responder: FSM states, PTE cache entry, dbus structs.
package ptw_mem_responder_pkg;

    localparam int PTE_TAG_LSB = 3;
    localparam int PTE_TAG_MSB = 55;
    localparam int PTE_TAG_W   = PTE_TAG_MSB - PTE_TAG_LSB + 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP, GAP} ptw_rsp_state_t;

    typedef struct packed {
        logic                 valid;
        logic [PTE_TAG_W-1:0] tag;
        logic [63:0]          data;
    } pte_cache_entry_t;

    typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // PTEs are 8-byte aligned, so the low three address bits carry no information.
    function automatic logic [PTE_TAG_W-1:0] pte_tag(input logic [63:0] addr);
        return addr[PTE_TAG_MSB:PTE_TAG_LSB];
    endfunction

endpackage

// File: rtl/ptw_mem_responder_cache.sv
// Small fully-associative PTE cache: combinational lookup, round-robin fill, bulk flush.
module pte_cache
    import ptw_mem_responder_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [PTE_TAG_W-1:0] lookup_tag,
    output logic                 hit,
    output logic [63:0]          hit_data,
    input  logic                 fill,
    input  logic [PTE_TAG_W-1:0] fill_tag,
    input  logic [63:0]          fill_data
);

    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    pte_cache_entry_t       entries [ENTRIES];
    logic [PTR_W-1:0]       ptr;

    // Tag match across all entries; tags are unique so OR-merging the data is safe.
    // A flush in the same cycle forces a miss.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entries[i].valid && entries[i].tag == lookup_tag) begin
                hit      = 1'b1;
                hit_data = hit_data | entries[i].data;
            end
        end
        if (flush) hit = 1'b0;
    end

    // Entry storage and replacement pointer; flush beats a same-cycle fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
            ptr <= '0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
        end else if (fill) begin
            entries[ptr] <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
            ptr          <= (ptr == PTR_W'(ENTRIES - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/ptw_mem_responder.sv
// PTE read responder for the Sv39 walker: cache hit path plus dbus miss path.
module ptw_mem_responder
    import ptw_mem_responder_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic [63:0] mem_addr,
    output logic [63:0] pte,
    output logic        pte_valid,
    input  logic        flush,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp,
    output logic        busy
);

    ptw_rsp_state_t state_q, state_d;
    logic [63:0]    addr_q;
    logic [63:0]    pte_q;
    logic           abort_q;    // walker dropped mem_req during the bus read
    logic           flushed_q;  // flush seen during the bus read: don't cache the result
    logic           hit;
    logic [63:0]    hit_data;
    logic           fill;

    // Only the tag bits of the address and the data_ok/data of the response matter.
    logic unused_bits;
    assign unused_bits = ^{mem_addr[63:56], mem_addr[2:0], dresp.addr_ok};

    pte_cache #(.ENTRIES(ENTRIES)) u_cache (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .lookup_tag (pte_tag(mem_addr)),
        .hit        (hit),
        .hit_data   (hit_data),
        .fill       (fill),
        .fill_tag   (pte_tag(addr_q)),
        .fill_data  (dresp.data)
    );

    assign fill = (state_q == BUS) && dresp.data_ok && !flushed_q;

    // Next-state logic; an abandoned walker request still waits for the bus.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mem_req) state_d = hit ? RESP : BUS;
            BUS:  if (dresp.data_ok) state_d = (abort_q || !mem_req) ? GAP : RESP;
            RESP: state_d = GAP;
            GAP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus address/PTE latches and the per-transaction flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            pte_q     <= '0;
            abort_q   <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                abort_q   <= 1'b0;
                flushed_q <= 1'b0;
                if (mem_req) begin
                    addr_q <= mem_addr;
                    if (hit) pte_q <= hit_data;
                end
            end
            if (state_q == BUS) begin
                if (!mem_req) abort_q   <= 1'b1;
                if (flush)    flushed_q <= 1'b1;
                if (dresp.data_ok) pte_q <= dresp.data;
            end
        end
    end

    // Bus request is a pure function of state so reset drops it immediately.
    always_comb begin
        dreq        = '0;
        dreq.valid  = (state_q == BUS);
        dreq.addr   = addr_q;
        dreq.size   = MSIZE8;
    end

    assign pte       = pte_q;
    assign pte_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Directed bench with a pte scoreboard; monitor pops on every pte_valid pulse.
module tb_ptw_mem_responder;
    import ptw_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] pte;
    logic        pte_valid;
    logic        flush;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          exp_pulses = 0;
    logic [63:0] exp_q[$];

    ptw_mem_responder #(.ENTRIES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .pte       (pte),
        .pte_valid (pte_valid),
        .flush     (flush),
        .dreq      (dreq),
        .dresp     (dresp),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && pte_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got pte %h expected no pulse", pte);
            end else begin
                chk("pte", pte, exp_q.pop_front());
            end
        end
    end

    // One walker request. Called at a negedge; returns at the GAP negedge (or IDLE after abort).
    task automatic do_req(input logic [63:0] a, input logic [63:0] d, input bit hit,
                          input int dly, input bit abort, input bit fl_bus, input bit hold);
        int n;
        if (!abort) begin
            exp_q.push_back(d);
            exp_pulses++;
        end
        mem_req  = 1'b1;
        mem_addr = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 20);
        if (!busy) begin
            chk("busy_timeout", {63'd0, busy}, 64'd1);
            mem_req = 1'b0;
            return;
        end
        if (hit) begin
            chk("hit_pulse", {63'd0, pte_valid}, 64'd1);
            chk("hit_no_dreq", {63'd0, dreq.valid}, 64'd0);
        end else begin
            chk("miss_dreq_valid", {63'd0, dreq.valid}, 64'd1);
            chk("miss_dreq_addr", dreq.addr, a);
            chk("miss_dreq_size", {61'd0, dreq.size}, {61'd0, MSIZE8});
            for (int i = 0; i < dly; i++) begin
                if (abort && i == 2) mem_req = 1'b0;
                if (fl_bus) flush = (i == 0);
                @(negedge clk);
                chk("dreq_held", {63'd0, dreq.valid}, 64'd1);
            end
            flush = 1'b0;
            dresp.data_ok = 1'b1;
            dresp.data    = d;
            @(negedge clk);
            dresp.data_ok = 1'b0;
            dresp.data    = '0;
            chk("resp_pulse", {63'd0, pte_valid}, {63'd0, !abort});
        end
        @(negedge clk);
        if (abort) begin
            chk("busy_after_abort", {63'd0, busy}, 64'd0);
        end else begin
            chk("gap_no_pulse", {63'd0, pte_valid}, 64'd0);
            chk("gap_busy", {63'd0, busy}, 64'd1);
        end
        if (!hold) mem_req = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int p0;
        reset    = 1'b1;
        mem_req  = 1'b0;
        mem_addr = '0;
        flush    = 1'b0;
        dresp    = '0;
        @(negedge clk);
        chk("rst_pte", pte, 64'd0);
        chk("rst_pte_valid", {63'd0, pte_valid}, 64'd0);
        chk("rst_dreq_valid", {63'd0, dreq.valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Cold miss, then hit
        do_req(64'h8000_1008, 64'h2000_0401, 0, 5, 0, 0, 0);
        do_req(64'h8000_1008, 64'h2000_0401, 1, 0, 0, 0, 0);

        // Three-level walk with mem_req held throughout
        p0 = pulses;
        do_req(64'h8000_1010, 64'h0000_0000_2000_0801, 0, 2, 0, 0, 1);
        do_req(64'h8000_2020, 64'h0000_0000_2000_0c01, 0, 3, 0, 0, 1);
        do_req(64'h8000_3030, 64'h0000_0000_2000_10cf, 0, 1, 0, 0, 0);
        chk("walk_pulses", 64'(pulses - p0), 64'd3);

        // Flush while idle -> miss; then refill hits
        do_flush();
        do_req(64'h8000_1008, 64'h2000_0411, 0, 2, 0, 0, 0);
        do_req(64'h8000_1008, 64'h2000_0411, 1, 0, 0, 0, 0);

        // Flush during BUS: data returned but not cached
        do_req(64'h8000_4040, 64'h0000_0000_0000_0033, 0, 3, 0, 1, 0);
        do_req(64'h8000_4040, 64'h0000_0000_0000_0044, 0, 2, 0, 0, 0);

        // Abort mid-BUS: no pulse, but the data is still cached
        do_req(64'h8000_5050, 64'h0000_0000_0000_0055, 0, 4, 1, 0, 0);
        do_req(64'h8000_5050, 64'h0000_0000_0000_0055, 1, 0, 0, 0, 0);

        // Round-robin replacement: fifth fill evicts the first
        do_flush();
        for (int i = 0; i < 5; i++)
            do_req(64'h8001_0000 + 64'(i * 8), 64'h100 + 64'(i), 0, 1, 0, 0, 0);
        do_req(64'h8001_0008, 64'h101, 1, 0, 0, 0, 0);
        do_req(64'h8001_0000, 64'h200, 0, 1, 0, 0, 0);

        // Reset mid-BUS drops dreq and busy at once
        mem_req  = 1'b1;
        mem_addr = 64'h8002_0000;
        repeat (3) @(negedge clk);
        chk("pre_rst_dreq", {63'd0, dreq.valid}, 64'd1);
        reset = 1'b1;
        #1;
        chk("midbus_rst_dreq", {63'd0, dreq.valid}, 64'd0);
        chk("midbus_rst_busy", {63'd0, busy}, 64'd0);
        mem_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        // Cache was cleared by reset
        do_req(64'h8001_0008, 64'h301, 0, 2, 0, 0, 0);

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("total_pulses", 64'(pulses), 64'(exp_pulses));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
